reaction_timer: RTL and testbench
=================================

# reaction_timer

Downstream consumer of the F1 start-light sequence: watches the 8-bit light bar driven by the F1 lights top, detects "lights out" (all eight lit, then all dark), and measures the driver's reaction time in milliseconds until the button is pressed. It flags jump starts, where the button is pressed before lights out. It produces a 4-digit BCD result for the hex displays.

## Interface
Parameters:
- MAX_MS, 9999: saturation value of the result in ms; must be ≤ 9999.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low (rst = 0 resets on the next clk edge).
- lights  input  8  light bar from the F1 lights block (data_out).
- tick  input  1  one-cycle 1 ms enable pulse from a clktick instance.
- button  input  1  driver button level (vbdFlag); rising edge = press.
- time_bcd  output  16  reaction time, 4 BCD digits, [15:12] = thousands.
- valid  output  1  high while time_bcd holds a completed measurement.
- jump_start  output  1  high while a foul is latched.
- timeout  output  1  high when the count saturated at MAX_MS without a press.
- busy  output  1  high in ARMED or TIMING.

## Operation
- Press detection: button is registered once (btn_q). press = button & ~btn_q.
- States:
  - IDLE: waiting for a sequence.
  - ARMED: lights are filling.
  - TIMING: lights are out, counting.
  - DONE: result held.
  - FOUL: jump start held.
- Transitions:
  - IDLE/DONE/FOUL → ARMED when lights != 0. On that edge, clear the counter, valid, jump_start and timeout.
  - ARMED → FOUL on press, regardless of lights.
  - ARMED → TIMING when the previous cycle's lights == 8'hFF and the current lights == 8'h00, with no press this cycle.
  - ARMED → IDLE when lights == 0 without passing through 8'hFF (aborted sequence). No flags are set.
  - TIMING → DONE on press: set valid and hold the count.
  - TIMING → DONE when the count reaches MAX_MS: set valid and timeout.
  - DONE/FOUL: stay, ignoring presses, until the next sequence starts (lights != 0).
- Simultaneous events:
  - Press in the same cycle as the 8'hFF→8'h00 transition → FOUL.
  - tick and press in the same TIMING cycle → the tick is not counted.
  - Entry to ARMED and press in the same cycle → ARMED only; the press is discarded.
- Counter: 4-digit BCD, increments by 1 per tick only in TIMING. Each digit wraps 9→0 with carry. The counter stops at MAX_MS and never wraps to 0000.
- Reset mid-operation: return to IDLE immediately and clear all outputs, btn_q and the previous-lights register.

## Timing
- Reset values: time_bcd = 16'h0000, valid = 0, jump_start = 0, timeout = 0, busy = 0, state = IDLE.
- All outputs are registered.
- Lights-out transition observed at edge N → busy and state TIMING from edge N; the first count is the first tick after edge N.
- Press rising edge seen on button before edge N → btn_q updates at N → state change at N. valid/jump_start assert at edge N+1 at the latest.
- time_bcd updates on the same edge as the counting tick. It is stable while valid = 1.
- Resolution: ±1 ms, because tick phase is free-running.

## Structure
- Package reaction_pkg:
  - state enum (IDLE, ARMED, TIMING, DONE, FOUL), 3 bits.
  - LIGHTS_ALL = 8'hFF and LIGHTS_OFF = 8'h00.
  - BCD digit typedef (4 bits).
- Sub-module bcd_counter. Ports: clk, rst, clr, en, max (16-bit BCD), count, at_max. Four cascaded digits with saturate-at-max.
- The top holds the FSM, press edge detect and previous-lights register.

## Test plan
- Normal run: lights 01→03→…→FF→00; 237 ticks; press → valid = 1, time_bcd = 16'h0237, jump_start = 0.
- Jump start: press while lights = 8'h1F → jump_start = 1, valid = 0; a later lights-out does not start counting.
- Same-cycle foul: press coincides with FF→00 → jump_start = 1, time_bcd = 0000.
- Timeout: lights out, no press, 9999 ticks → valid = 1, timeout = 1, time_bcd = 16'h9999. The 10000th tick leaves it unchanged.
- BCD carry: press after 1000 ticks → time_bcd = 16'h1000. Tick and press in the same cycle after 99 ticks → 16'h0099.
- Reset mid-TIMING (rst = 0 for one cycle at count 0050) → all outputs 0 and IDLE. A new sequence measures from 0.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: FSM states, light-bar
// patterns and a BCD helper for turning the saturation limit into digits.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FOUL
  } state_t;

  localparam logic [7:0] LIGHTS_ALL = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF = 8'h00;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [15:0] to_bcd(input int unsigned value);
    logic [15:0] r;
    int unsigned v;
    v = value;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Light bar, tick and button in; measured time and status flags out.
interface reaction_timer_if;
  logic [7:0]  lights;
  logic        tick;
  logic        button;
  logic [15:0] time_bcd;
  logic        valid;
  logic        jump_start;
  logic        timeout;
  logic        busy;

  modport master (
    output lights, tick, button,
    input  time_bcd, valid, jump_start, timeout, busy
  );

  modport slave (
    input  lights, tick, button,
    output time_bcd, valid, jump_start, timeout, busy
  );
endinterface

// File: rtl/reaction_timer_bcd_counter.sv
// Four cascaded BCD digits that count up on en and stop exactly at max.
module bcd_counter
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] max,
  output logic [15:0] count,
  output logic        at_max
);

  bcd_digit_t digit_q [4];
  logic [3:0] carry;

  assign at_max   = (count == max);
  assign carry[0] = en & ~at_max;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] & (digit_q[gi] == 4'd9);
      end

      always_ff @(posedge clk) begin
        if (!rst || clr) begin
          digit_q[gi] <= '0;
        end else if (carry[gi]) begin
          digit_q[gi] <= (digit_q[gi] == 4'd9) ? 4'd0 : digit_q[gi] + 4'd1;
        end
      end

      assign count[gi*4 +: 4] = digit_q[gi];
    end
  endgenerate

endmodule

// File: rtl/reaction_timer.sv
// Watches the start-light bar for lights out, times the driver's button press
// in BCD milliseconds and flags jump starts and timeouts.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int MAX_MS = 9999
) (
  input logic             clk,
  input logic             rst,
  reaction_timer_if.slave bus
);

  localparam logic [15:0] MAX_BCD = to_bcd(MAX_MS);

  state_t      state_q;
  logic        btn_q;
  logic [7:0]  prev_lights_q;
  logic        valid_q;
  logic        jump_q;
  logic        timeout_q;
  logic        busy_q;
  logic [15:0] count;
  logic        at_max;

  logic press;
  logic seq_start;
  logic lights_out;
  logic resting;

  assign press      = bus.button & ~btn_q;
  // A new sequence is the bar leaving all-dark, so a foul mid-fill stays latched
  // through the rest of that same sequence.
  assign seq_start  = (prev_lights_q == LIGHTS_OFF) && (bus.lights != LIGHTS_OFF);
  assign lights_out = (prev_lights_q == LIGHTS_ALL) && (bus.lights == LIGHTS_OFF);
  assign resting    = (state_q == IDLE) || (state_q == DONE) || (state_q == FOUL);

  bcd_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (resting && seq_start),
    .en     ((state_q == TIMING) && bus.tick && !press),
    .max    (MAX_BCD),
    .count  (count),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      btn_q         <= 1'b0;
      prev_lights_q <= LIGHTS_OFF;
      valid_q       <= 1'b0;
      jump_q        <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      btn_q         <= bus.button;
      prev_lights_q <= bus.lights;
      case (state_q)
        IDLE, DONE, FOUL: begin
          if (seq_start) begin
            state_q   <= ARMED;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            jump_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ARMED: begin
          if (press) begin
            state_q <= FOUL;
            busy_q  <= 1'b0;
            jump_q  <= 1'b1;
          end else if (lights_out) begin
            state_q <= TIMING;
          end else if (bus.lights == LIGHTS_OFF) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        TIMING: begin
          // A press wins over saturation and over a coincident tick.
          if (press) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else if (at_max) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_bcd   = count;
  assign bus.valid      = valid_q;
  assign bus.jump_start = jump_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed scenarios plus randomized sequences for reaction_timer, compared
// every cycle against an event-level model of the driver reaction rules.
module tb_reaction_timer;

  localparam int MAX = 9999;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reaction_timer_if bus ();

  reaction_timer #(.MAX_MS(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: a sequence is either resting, filling, or counting milliseconds.
  bit       m_filling, m_counting, m_valid, m_jump, m_timeout;
  int       m_ms;
  bit [7:0] m_prev;
  bit       m_btn;

  function automatic logic [15:0] tb_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit press;
    bit lights_out;
    if (!rst) begin
      m_filling = 0; m_counting = 0; m_valid = 0; m_jump = 0; m_timeout = 0;
      m_ms = 0; m_prev = 8'h00; m_btn = 0;
    end else begin
      press      = bus.button && !m_btn;
      lights_out = (m_prev == 8'hFF) && (bus.lights == 8'h00);
      if (m_counting) begin
        if (press) begin
          m_counting = 0; m_valid = 1;
        end else if (m_ms == MAX) begin
          m_counting = 0; m_valid = 1; m_timeout = 1;
        end else if (bus.tick) begin
          m_ms++;
        end
      end else if (m_filling) begin
        if (press) begin
          m_filling = 0; m_jump = 1;
        end else if (lights_out) begin
          m_filling = 0; m_counting = 1;
        end else if (bus.lights == 8'h00) begin
          m_filling = 0;
        end
      end else if (m_prev == 8'h00 && bus.lights != 8'h00) begin
        m_filling = 1; m_ms = 0; m_valid = 0; m_jump = 0; m_timeout = 0;
      end
      m_prev = bus.lights;
      m_btn  = bus.button;
    end
    #1;
    check("time_bcd", bus.time_bcd, tb_bcd(m_ms));
    check("valid", 16'(bus.valid), 16'(m_valid));
    check("jump_start", 16'(bus.jump_start), 16'(m_jump));
    check("timeout", 16'(bus.timeout), 16'(m_timeout));
    check("busy", 16'(bus.busy), 16'(m_filling | m_counting));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input int from, input int upto);
    for (int k = from; k <= upto; k++) begin
      bus.lights = 8'((1 << k) - 1);
      cyc($urandom_range(1, 3));
    end
  endtask

  task automatic start_timing();
    fill(1, 8);
    bus.lights = 8'h00;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc($urandom_range(0, 2));
    end
  endtask

  task automatic press_btn();
    bus.button = 1'b1;
    cyc(1);
    bus.button = 1'b0;
    cyc(2);
  endtask

  initial begin
    bus.lights = 8'h00;
    bus.tick   = 1'b0;
    bus.button = 1'b0;
    cyc(3);
    check("rst_time_bcd", bus.time_bcd, 16'h0000);
    check("rst_valid", 16'(bus.valid), 16'h0);
    check("rst_jump", 16'(bus.jump_start), 16'h0);
    check("rst_timeout", 16'(bus.timeout), 16'h0);
    check("rst_busy", 16'(bus.busy), 16'h0);
    rst = 1'b1;
    cyc(2);

    start_timing();
    check("normal_busy", 16'(bus.busy), 16'h1);
    ticks(237);
    press_btn();
    check("normal_valid", 16'(bus.valid), 16'h1);
    check("normal_bcd", bus.time_bcd, 16'h0237);
    check("normal_jump", 16'(bus.jump_start), 16'h0);
    $display("scenario normal run: time_bcd=%h valid=%b", bus.time_bcd, bus.valid);

    fill(1, 5);
    bus.button = 1'b1;
    cyc(1);
    bus.button = 1'b0;
    fill(6, 8);
    bus.lights = 8'h00;
    cyc(1);
    ticks(20);
    check("jump_flag", 16'(bus.jump_start), 16'h1);
    check("jump_valid", 16'(bus.valid), 16'h0);
    check("jump_bcd", bus.time_bcd, 16'h0000);
    $display("scenario jump start: jump_start=%b busy=%b", bus.jump_start, bus.busy);

    fill(1, 8);
    bus.lights = 8'h00;
    bus.button = 1'b1;
    cyc(1);
    bus.button = 1'b0;
    ticks(5);
    check("samecyc_jump", 16'(bus.jump_start), 16'h1);
    check("samecyc_bcd", bus.time_bcd, 16'h0000);
    $display("scenario same-cycle foul: jump_start=%b", bus.jump_start);

    start_timing();
    bus.tick = 1'b1;
    cyc(MAX);
    bus.tick = 1'b0;
    cyc(2);
    check("timeout_valid", 16'(bus.valid), 16'h1);
    check("timeout_flag", 16'(bus.timeout), 16'h1);
    check("timeout_bcd", bus.time_bcd, 16'h9999);
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    cyc(1);
    check("timeout_hold", bus.time_bcd, 16'h9999);
    $display("scenario timeout: time_bcd=%h timeout=%b", bus.time_bcd, bus.timeout);

    start_timing();
    ticks(1000);
    press_btn();
    check("carry_1000", bus.time_bcd, 16'h1000);
    $display("scenario carry 1000: time_bcd=%h", bus.time_bcd);

    start_timing();
    ticks(99);
    bus.tick   = 1'b1;
    bus.button = 1'b1;
    cyc(1);
    bus.tick   = 1'b0;
    bus.button = 1'b0;
    cyc(2);
    check("tick_press_0099", bus.time_bcd, 16'h0099);
    $display("scenario tick+press: time_bcd=%h", bus.time_bcd);

    start_timing();
    ticks(50);
    check("pre_reset_bcd", bus.time_bcd, 16'h0050);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    check("midreset_bcd", bus.time_bcd, 16'h0000);
    check("midreset_busy", 16'(bus.busy), 16'h0);
    check("midreset_valid", 16'(bus.valid), 16'h0);
    start_timing();
    ticks(12);
    press_btn();
    check("after_reset_bcd", bus.time_bcd, 16'h0012);
    $display("scenario reset mid-timing: time_bcd=%h", bus.time_bcd);

    bus.lights = 8'h01;
    bus.button = 1'b1;
    cyc(1);
    bus.button = 1'b0;
    fill(2, 8);
    bus.lights = 8'h00;
    cyc(1);
    ticks(30);
    press_btn();
    check("arm_press_jump", 16'(bus.jump_start), 16'h0);
    check("arm_press_bcd", bus.time_bcd, 16'h0030);
    $display("scenario press on arming: time_bcd=%h", bus.time_bcd);

    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int k = 1; k <= n; k++) begin
        bus.lights = 8'((1 << k) - 1);
        bus.button = ($urandom_range(0, 11) == 0);
        bus.tick   = $urandom_range(0, 1);
        cyc($urandom_range(1, 3));
      end
      bus.lights = 8'h00;
      bus.button = ($urandom_range(0, 9) == 0);
      cyc(1);
      for (int c = 0; c < $urandom_range(0, 400); c++) begin
        bus.tick   = $urandom_range(0, 1);
        bus.button = ($urandom_range(0, 59) == 0) ? ~bus.button : bus.button;
        rst        = ($urandom_range(0, 999) != 0);
        cyc(1);
      end
      rst        = 1'b1;
      bus.tick   = 1'b0;
      bus.button = 1'b0;
      cyc(2);
      $display("random sequence %0d: lights_to=%0d time_bcd=%h valid=%b jump=%b timeout=%b",
               it, n, bus.time_bcd, bus.valid, bus.jump_start, bus.timeout);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
